alu_mc: RTL and testbench

Parametrised, multi-cycle successor to the team's combinational 8-bit ALU. It registers operands under a valid/ready handshake and computes logic, add/sub, compare and shift results in one cycle. Unsigned multiply runs as an iterative shift-add over WIDTH cycles. It returns a registered result with zero/carry/overflow/negative flags, and sits between the decode stage and writeback/flag register of the datapath.

---
 rtl/alu_mc.sv | 150 +++++++++++++++
 tb/tb_alu_mc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake and iterative shift-add multiply
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_NOT  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nx;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [SHW:0]         count;
    logic                 accept;
    logic                 is_mul;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;

    assign accept = in_valid && in_ready;
    assign is_mul = (ctrl == OP_MUL);

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = is_mul ? BUSY : DONE;
            end
            BUSY: begin
                if (count == '0) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nx = in_valid ? (is_mul ? BUSY : DONE) : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle datapath; only sampled into the result register on accept.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ctrl)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = a << b[SHW-1:0];
            OP_SRL:  alu_res = a >> b[SHW-1:0];
            OP_SRA:  alu_res = $signed(a) >>> b[SHW-1:0];
            OP_NOT:  alu_res = ~a;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                if (is_mul) begin
                    mcand  <= {{WIDTH{1'b0}}, a};
                    mplier <= b;
                    acc    <= '0;
                    count  <= (SHW+1)'(WIDTH);
                end else begin
                    result   <= alu_res;
                    zero     <= (alu_res == '0);
                    carry    <= alu_c;
                    overflow <= alu_v;
                    negative <= alu_res[WIDTH-1];
                end
            end else if (state == BUSY) begin
                if (count != '0) begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - 1'b1;
                end else begin
                    // Extra cycle after the last iteration publishes the product.
                    result   <= acc[WIDTH-1:0];
                    zero     <= (acc[WIDTH-1:0] == '0);
                    carry    <= |acc[2*WIDTH-1:WIDTH];
                    overflow <= |acc[2*WIDTH-1:WIDTH];
                    negative <= acc[WIDTH-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized self-checking bench for alu_mc at WIDTH=8
module tb_alu_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] ctrl;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero, carry, overflow, negative;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_mc #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ctrl(ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry),
        .overflow(overflow), .negative(negative)
    );

    always #5 clk = ~clk;

    // Reference: {result, zero, carry, overflow, negative} from integer arithmetic.
    function automatic logic [11:0] model(input logic [7:0] x, input logic [7:0] y, input logic [3:0] op);
        int ua = x;
        int ub = y;
        int sa = $signed(x);
        int sb = $signed(y);
        int r  = 0;
        bit c  = 0;
        bit v  = 0;
        logic [7:0] r8;
        case (op)
            4'd0:  r = ua & ub;
            4'd1:  r = ua | ub;
            4'd3:  r = ua ^ ub;
            4'd2:  begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd6:  begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd7:  r = (sa < sb) ? 1 : 0;
            4'd8:  r = (ua < ub) ? 1 : 0;
            4'd4:  r = ua << (ub % 8);
            4'd5:  r = ua >> (ub % 8);
            4'd13: r = sa >>> (ub % 8);
            4'd12: r = ~ua;
            4'd10: begin r = ua * ub; c = (r > 255); v = c; end
            default: r = 0;
        endcase
        r8 = r[7:0];
        return {r8, (r8 == 8'h00), c, v, r8[7]};
    endfunction

    // Issue one op from IDLE, return edges-to-out_valid (-1 on timeout) and outputs; then consume.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic [3:0] op,
                         output int lat, output logic [11:0] obs);
        a = x; b = y; ctrl = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (out_valid) begin lat = k - 1; break; end
            @(posedge clk); #1;
        end
        if (lat == -1 && out_valid) lat = 40;
        if (lat == 0) lat = 1;
        obs = {result, zero, carry, overflow, negative};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int seen = 0;
        n_cmp++;
        if ({out_valid, in_ready, result, zero, carry, overflow, negative} !== {1'b0, 1'b1, 8'h00, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_state got ov=%b ir=%b res=%h flags=%b%b%b%b want ov=0 ir=1 res=00 flags=0000",
                     out_valid, in_ready, result, zero, carry, overflow, negative);
        end
        a = 8'h0F; b = 8'h0F; ctrl = 4'b1010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid_mul got ov=%b ir=%b res=%h want ov=0 ir=1 res=00", out_valid, in_ready, result);
        end
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_abort got out_valid for %0d cycles want 0", seen);
        end
    endtask

    task automatic test_add();
        int lat;
        logic [11:0] obs;
        logic [7:0] x, y;
        do_op(8'h7F, 8'h01, 4'b0010, lat, obs);
        n_cmp++;
        if (obs !== {8'h80, 4'b0011} || lat !== 1) begin
            n_fail++;
            $display("FAIL add_ovf got %h lat %0d want %h lat 1", obs, lat, {8'h80, 4'b0011});
        end
        do_op(8'hFF, 8'h01, 4'b0010, lat, obs);
        n_cmp++;
        if (obs !== {8'h00, 4'b1100}) begin
            n_fail++;
            $display("FAIL add_carry got %h want %h", obs, {8'h00, 4'b1100});
        end
        for (int i = 0; i < 10; i++) begin
            x = 8'($urandom); y = 8'($urandom);
            do_op(x, y, 4'b0010, lat, obs);
            n_cmp++;
            if (obs !== model(x, y, 4'b0010)) begin
                n_fail++;
                $display("FAIL add_rand a=%h b=%h got %h want %h", x, y, obs, model(x, y, 4'b0010));
            end
        end
    endtask

    task automatic test_sub_cmp();
        int lat;
        logic [11:0] obs;
        do_op(8'h03, 8'h05, 4'b0110, lat, obs);
        n_cmp++;
        if (obs[11:4] !== 8'hFE || obs[2] !== 1'b1 || obs !== model(8'h03, 8'h05, 4'b0110)) begin
            n_fail++;
            $display("FAIL sub got %h want %h", obs, model(8'h03, 8'h05, 4'b0110));
        end
        do_op(8'hFF, 8'h01, 4'b0111, lat, obs);
        n_cmp++;
        if (obs[11:4] !== 8'h01) begin
            n_fail++;
            $display("FAIL slt got %h want 01", obs[11:4]);
        end
        do_op(8'hFF, 8'h01, 4'b1000, lat, obs);
        n_cmp++;
        if (obs[11:4] !== 8'h00 || obs[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL sltu got %h z=%b want 00 z=1", obs[11:4], obs[3]);
        end
    endtask

    task automatic test_mul_backpressure();
        int lat = -1;
        logic [7:0] held;
        a = 8'h10; b = 8'h11; ctrl = 4'b1010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = k; break; end
        end
        n_cmp++;
        if (lat !== 9 || {result, carry, overflow} !== {8'h10, 2'b11}) begin
            n_fail++;
            $display("FAIL mul_basic got lat=%0d res=%h c=%b v=%b want lat=9 res=10 c=1 v=1",
                     lat, result, carry, overflow);
        end
        held = 8'h10;
        for (int k = 0; k < 5; k++) begin
            a = 8'($urandom); b = 8'($urandom); ctrl = 4'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, held}) begin
                n_fail++;
                $display("FAIL mul_hold cycle %0d got ov=%b ir=%b res=%h want ov=1 ir=0 res=%h",
                         k, out_valid, in_ready, result, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] xa [5] = '{8'hF0, 8'hF0, 8'hF0, 8'h80, 8'h12};
        logic [7:0] xb [5] = '{8'h3C, 8'h3C, 8'h3C, 8'h03, 8'h34};
        logic [3:0] xc [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b1101, 4'b1111};
        logic [7:0] xr [5] = '{8'h30, 8'hFC, 8'hCC, 8'hF0, 8'h00};
        out_ready = 1'b1;
        a = xa[0]; b = xb[0]; ctrl = xc[0]; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b1, xr[i]} || zero !== (xr[i] == 8'h00)) begin
                n_fail++;
                $display("FAIL b2b op %0d got ov=%b ir=%b res=%h z=%b want ov=1 ir=1 res=%h",
                         i, out_valid, in_ready, result, zero, xr[i]);
            end
            if (i < 4) begin
                a = xa[i+1]; b = xb[i+1]; ctrl = xc[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_input_stability();
        int lat = -1;
        a = 8'h03; b = 8'h05; ctrl = 4'b1010; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 20; k++) begin
            a = 8'($urandom); b = 8'($urandom); ctrl = 4'($urandom);
            @(posedge clk); #1;
            if (out_valid) begin lat = k; break; end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (lat !== 9 || {result, zero, carry, overflow, negative} !== {8'h0F, 4'b0000}) begin
            n_fail++;
            $display("FAIL mul_stable got lat=%0d res=%h want lat=9 res=0f flags=0000", lat, result);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat;
        logic [11:0] obs;
        logic [7:0] x, y;
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom); y = 8'($urandom); op = 4'($urandom);
            if (i % 8 == 0) op = 4'b1010;
            do_op(x, y, op, lat, obs);
            n_cmp++;
            if (obs !== model(x, y, op) || lat !== ((op == 4'b1010) ? 9 : 1)) begin
                n_fail++;
                $display("FAIL rand op=%b a=%h b=%h got %h lat %0d want %h",
                         op, x, y, obs, lat, model(x, y, op));
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ctrl = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_add();
        test_sub_cmp();
        test_mul_backpressure();
        test_back_to_back();
        test_input_stability();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
